// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg
// Shared port ids, lock-state encoding and default hold limit for the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DBG = 1'b1;
  localparam int   ARB_MAX_HOLD = 4;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_lock_e;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick
// Combinational grant selection: round-robin with a bounded lock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             last_grant,
  input  arb_lock_e        lock_state,
  input  logic             lock_owner,
  input  logic [CNT_W-1:0] hold_cnt,
  output logic             grant_valid,
  output logic             grant_idx
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  always_comb begin
    grant_valid = valid_0 | valid_1;
    grant_idx   = ARB_PORT_CPU;
    if (valid_0 && valid_1) begin
      if (lock_state == ARB_UNLOCKED) begin
        grant_idx = other_port(last_grant);
      end else if (hold_cnt < HOLD_LIMIT) begin
        grant_idx = lock_owner;
      end else begin
        // Owner has used its full hold budget while the other port waited.
        grant_idx = other_port(lock_owner);
      end
    end else if (valid_1) begin
      grant_idx = ARB_PORT_DBG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Two-port main-memory arbiter with bounded lock and registered read response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_we_0,
  input  logic              req_lock_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              req_ready_0,
  output logic              resp_valid_0,
  output logic [DATA_W-1:0] resp_rdata_0,
  input  logic              req_valid_1,
  input  logic              req_we_1,
  input  logic              req_lock_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_ready_1,
  output logic              resp_valid_1,
  output logic [DATA_W-1:0] resp_rdata_1,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W      = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE   = CNT_W'(1);

  logic             last_grant_q, last_grant_d;
  arb_lock_e        lock_state_q, lock_state_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic             resp_valid_0_q, resp_valid_0_d;
  logic             resp_valid_1_q, resp_valid_1_d;
  logic [DATA_W-1:0] resp_rdata_0_q, resp_rdata_0_d;
  logic [DATA_W-1:0] resp_rdata_1_q, resp_rdata_1_d;

  logic             pick_valid;
  logic             grant_valid;
  logic             grant_idx;
  logic             grant_we;
  logic             grant_lock;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  mem_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_pick (
    .valid_0     (req_valid_0),
    .valid_1     (req_valid_1),
    .last_grant  (last_grant_q),
    .lock_state  (lock_state_q),
    .lock_owner  (lock_owner_q),
    .hold_cnt    (hold_cnt_q),
    .grant_valid (pick_valid),
    .grant_idx   (grant_idx)
  );

  // Nothing may be accepted while reset is held, even though requests are live.
  assign grant_valid = pick_valid & rst;
  assign grant_we    = (grant_idx == ARB_PORT_DBG) ? req_we_1    : req_we_0;
  assign grant_lock  = (grant_idx == ARB_PORT_DBG) ? req_lock_1  : req_lock_0;
  assign grant_addr  = (grant_idx == ARB_PORT_DBG) ? req_addr_1  : req_addr_0;
  assign grant_wdata = (grant_idx == ARB_PORT_DBG) ? req_wdata_1 : req_wdata_0;

  always_comb begin
    req_ready_0 = grant_valid & (grant_idx == ARB_PORT_CPU);
    req_ready_1 = grant_valid & (grant_idx == ARB_PORT_DBG);
    mem_wen     = grant_valid & grant_we;
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    if (grant_valid) begin
      mem_raddr = grant_addr;
      mem_waddr = grant_addr;
      mem_wdata = grant_wdata;
    end
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    lock_state_d   = lock_state_q;
    lock_owner_d   = lock_owner_q;
    hold_cnt_d     = hold_cnt_q;
    resp_valid_0_d = 1'b0;
    resp_valid_1_d = 1'b0;
    resp_rdata_0_d = resp_rdata_0_q;
    resp_rdata_1_d = resp_rdata_1_q;
    if (grant_valid) begin
      last_grant_d = grant_idx;
      lock_state_d = grant_lock ? ARB_LOCKED : ARB_UNLOCKED;
      lock_owner_d = grant_idx;
      if (grant_idx == last_grant_q) begin
        hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
      end else begin
        hold_cnt_d = HOLD_ONE;
      end
      if (!grant_we) begin
        if (grant_idx == ARB_PORT_DBG) begin
          resp_valid_1_d = 1'b1;
          resp_rdata_1_d = mem_rdata;
        end else begin
          resp_valid_0_d = 1'b1;
          resp_rdata_0_d = mem_rdata;
        end
      end
    end else begin
      lock_state_d = ARB_UNLOCKED;
      hold_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q   <= ARB_PORT_DBG;
      lock_state_q   <= ARB_UNLOCKED;
      lock_owner_q   <= ARB_PORT_CPU;
      hold_cnt_q     <= '0;
      resp_valid_0_q <= 1'b0;
      resp_valid_1_q <= 1'b0;
      resp_rdata_0_q <= '0;
      resp_rdata_1_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      lock_state_q   <= lock_state_d;
      lock_owner_q   <= lock_owner_d;
      hold_cnt_q     <= hold_cnt_d;
      resp_valid_0_q <= resp_valid_0_d;
      resp_valid_1_q <= resp_valid_1_d;
      resp_rdata_0_q <= resp_rdata_0_d;
      resp_rdata_1_q <= resp_rdata_1_d;
    end
  end

  assign resp_valid_0 = resp_valid_0_q;
  assign resp_valid_1 = resp_valid_1_q;
  assign resp_rdata_0 = resp_rdata_0_q;
  assign resp_rdata_1 = resp_rdata_1_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Directed and randomized checking of mem_port_arbiter against a grant model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid_0 = 1'b0, req_we_0 = 1'b0, req_lock_0 = 1'b0;
  logic [ADDR_W-1:0] req_addr_0 = '0;
  logic [DATA_W-1:0] req_wdata_0 = '0;
  logic              req_valid_1 = 1'b0, req_we_1 = 1'b0, req_lock_1 = 1'b0;
  logic [ADDR_W-1:0] req_addr_1 = '0;
  logic [DATA_W-1:0] req_wdata_1 = '0;
  logic              req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
  logic [DATA_W-1:0] resp_rdata_0, resp_rdata_1;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_wen;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid_0 (req_valid_0), .req_we_0 (req_we_0), .req_lock_0 (req_lock_0),
    .req_addr_0 (req_addr_0), .req_wdata_0 (req_wdata_0), .req_ready_0 (req_ready_0),
    .resp_valid_0 (resp_valid_0), .resp_rdata_0 (resp_rdata_0),
    .req_valid_1 (req_valid_1), .req_we_1 (req_we_1), .req_lock_1 (req_lock_1),
    .req_addr_1 (req_addr_1), .req_wdata_1 (req_wdata_1), .req_ready_1 (req_ready_1),
    .resp_valid_1 (resp_valid_1), .resp_rdata_1 (resp_rdata_1),
    .mem_raddr (mem_raddr), .mem_waddr (mem_waddr), .mem_wdata (mem_wdata),
    .mem_wen (mem_wen), .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'h5A, a, ~a, a};
  endfunction

  // Memory device: stores data XOR a per-address pattern so unwritten words read as pat().
  logic [31:0] tb_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_wen && mem_waddr < 32'd256)
      tb_mem[mem_waddr[7:0]] <= mem_wdata ^ pat(mem_waddr[7:0]);
  end
  assign mem_rdata = (mem_raddr < 32'd256) ?
                     (tb_mem[mem_raddr[7:0]] ^ pat(mem_raddr[7:0])) : 32'hBAD0_BAD0;

  int          checks = 0;
  int          failures = 0;
  int          m_last, m_owner, m_cnt;
  bit          m_locked;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [256];
  bit          acc0, acc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_owner = 0; m_cnt = 0; m_locked = 0;
    exp_rv[0] = 0; exp_rv[1] = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  // Grant rules: single requester wins; on a tie the lock owner keeps the
  // port until it has taken MAX_HOLD consecutive beats, else round-robin.
  function automatic int pick(input bit v0, input bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (v1 && !v0)  return 1;
    if (!m_locked)  return 1 - m_last;
    if (m_cnt < MAX_HOLD) return m_owner;
    return 1 - m_owner;
  endfunction

  task automatic model_accept(input int g);
    logic        we, lk;
    logic [31:0] a, d;
    exp_rv[0] = 0; exp_rv[1] = 0;
    if (g < 0) begin
      m_locked = 0; m_cnt = 0;
      return;
    end
    we = (g == 1) ? req_we_1    : req_we_0;
    lk = (g == 1) ? req_lock_1  : req_lock_0;
    a  = (g == 1) ? req_addr_1  : req_addr_0;
    d  = (g == 1) ? req_wdata_1 : req_wdata_0;
    if (we) ref_mem[a[7:0]] = d;
    else begin
      exp_rv[g] = 1;
      exp_rd[g] = ref_mem[a[7:0]];
    end
    m_cnt    = (g == m_last) ? ((m_cnt < MAX_HOLD) ? m_cnt + 1 : MAX_HOLD) : 1;
    m_last   = g;
    m_owner  = g;
    m_locked = lk;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int          g;
    logic [31:0] ea, ed;
    logic        ewe;
    @(negedge clk);
    if (!rst) begin
      model_reset();
      g = -1;
    end else begin
      g = pick(req_valid_0, req_valid_1);
    end
    ea  = (g == 0) ? req_addr_0  : (g == 1) ? req_addr_1  : 32'd0;
    ed  = (g == 0) ? req_wdata_0 : (g == 1) ? req_wdata_1 : 32'd0;
    ewe = (g == 0) ? req_we_0    : (g == 1) ? req_we_1    : 1'b0;
    chk("req_ready_0", req_ready_0, g == 0);
    chk("req_ready_1", req_ready_1, g == 1);
    chk("mem_wen", mem_wen, ewe);
    chk("mem_raddr", mem_raddr, ea);
    chk("mem_waddr", mem_waddr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("resp_valid_0", resp_valid_0, exp_rv[0]);
    chk("resp_rdata_0", resp_rdata_0, exp_rd[0]);
    chk("resp_valid_1", resp_valid_1, exp_rv[1]);
    chk("resp_rdata_1", resp_rdata_1, exp_rd[1]);
    @(posedge clk);
    if (rst) model_accept(g);
    acc0 = (g == 0);
    acc1 = (g == 1);
    #1;
  endtask

  task automatic new_req(input int p);
    logic        v, we, lk;
    logic [31:0] a, d;
    v  = ($urandom_range(0, 3) != 0);
    we = ($urandom_range(0, 2) == 0);
    lk = $urandom_range(0, 1) == 1;
    a  = $urandom_range(0, 15);
    d  = $urandom;
    if (p == 0) begin
      req_valid_0 = v; req_we_0 = we; req_lock_0 = lk; req_addr_0 = a; req_wdata_0 = d;
    end else begin
      req_valid_1 = v; req_we_1 = we; req_lock_1 = lk; req_addr_1 = a; req_wdata_1 = d;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i[7:0]);
    model_reset();

    // Reset held with both ports requesting: nothing granted.
    req_valid_0 = 1; req_addr_0 = 32'h10;
    req_valid_1 = 1; req_addr_1 = 32'h20;
    step(); step();

    // Release: port 0 first, then strict alternation with responses.
    rst = 1;
    repeat (6) step();

    // Locked burst from port 0 while port 1 waits.
    req_lock_0 = 1; req_addr_0 = 32'h11;
    req_addr_1 = 32'h21;
    for (int i = 0; i < 7; i++) begin
      step();
      if (acc1) req_valid_1 = 0;
    end

    // Port 1 writes, port 0 reads the same word next cycle.
    req_valid_0 = 0; req_lock_0 = 0;
    req_valid_1 = 1; req_we_1 = 1; req_addr_1 = 32'h40; req_wdata_1 = 32'hDEADBEEF;
    step();
    req_valid_1 = 0; req_we_1 = 0;
    req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 32'h40;
    step();
    chk("wr_rd_valid", resp_valid_0, 1'b1);
    chk("wr_rd_data", resp_rdata_0, 32'hDEADBEEF);
    req_valid_0 = 0;
    step();

    // Reset the cycle after a locked read by port 1 is accepted.
    req_valid_1 = 1; req_we_1 = 0; req_lock_1 = 1; req_addr_1 = 32'h05;
    step();
    chk("pre_rst_valid", resp_valid_1, 1'b1);
    rst = 0;
    #1;
    chk("rst_drop_valid", resp_valid_1, 1'b0);
    chk("rst_drop_rdata", resp_rdata_1, 32'h0);
    req_valid_0 = 1; req_addr_0 = 32'h06; req_lock_0 = 0; req_lock_1 = 0;
    step(); step();
    rst = 1;
    step(); step();

    // Lock owner drops valid: the other port is granted that cycle.
    req_valid_1 = 0; req_valid_0 = 1; req_lock_0 = 1;
    step();
    req_valid_0 = 0; req_valid_1 = 1; req_lock_1 = 0;
    step();
    req_valid_1 = 0; req_lock_0 = 0;
    step();

    // Randomized traffic respecting hold-until-ready.
    for (int i = 0; i < 500; i++) begin
      if (!req_valid_0 || acc0) new_req(0);
      if (!req_valid_1 || acc1) new_req(1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
